xintf_dpbram_bridge: RTL and testbench

//  Synchronous bridge between the DSP XINTF async bus and two DPBRAM ports (write port, read port).

---
 rtl/xintf_dpbram_bridge.sv | 190 +++++++++++++++++++
 tb/tb_xintf_dpbram_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xintf_dpbram_bridge.sv
// xintf_dpbram_bridge
// Synchronous bridge from the asynchronous DSP XINTF bus to dual-port block RAMs.
// The bus strobes are synchronised, and each access becomes one FSM transaction
// that issues exactly one single-cycle RAM pulse. When waveform mode is latched,
// reads are served from the waveform RAM and writes are rejected and flagged.
module xintf_dpbram_bridge #(
   parameter int AW          = 9,
   parameter int DW          = 16,
   parameter int SYNC_STAGES = 2,
   parameter int RD_LAT      = 1,
   parameter int CNT_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wf_en,
   input  logic             i_dsp_ce,
   input  logic             i_dsp_we,
   input  logic             i_dsp_rd,
   input  logic [AW-1:0]    i_dsp_xa,
   input  logic [DW-1:0]    i_dsp_xd,
   output logic [DW-1:0]    o_dsp_xd,
   output logic             o_dsp_xd_oe,
   output logic [AW-1:0]    o_w_ram_addr,
   output logic             o_w_ram_ce,
   output logic             o_w_ram_we,
   output logic [DW-1:0]    o_w_ram_din,
   output logic [AW-1:0]    o_r_ram_addr,
   output logic             o_r_ram_ce,
   input  logic [DW-1:0]    i_r_ram_dout,
   output logic [AW-1:0]    o_wf_ram_addr,
   output logic             o_wf_ram_ce,
   input  logic [DW-1:0]    i_wf_ram_dout,
   output logic [CNT_W-1:0] o_wr_cnt,
   output logic [CNT_W-1:0] o_rd_cnt,
   output logic             o_err,
   output logic             o_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RD_HOLD,
      S_WR_HOLD,
      S_WR_COMMIT
   } state_t;

   state_t r_state, w_state_next;

   logic [SYNC_STAGES-1:0] r_ce_sync, r_we_sync, r_rd_sync;
   logic [SYNC_STAGES-1:0] r_settle;
   logic                   r_armed;
   logic [AW-1:0]          r_addr;
   logic [DW-1:0]          r_din;
   logic                   r_wf;
   logic [2:0]             r_lat_cnt;
   logic [DW-1:0]          r_xd;
   logic                   r_err;
   logic [CNT_W-1:0]       r_wr_cnt, r_rd_cnt;

   logic w_ce_s, w_we_s, w_rd_s;
   logic w_wr_act, w_rd_act;
   logic w_start;
   logic w_conflict, w_rd_capture, w_rd_done, w_wr_commit, w_wf_wr_err;

   assign w_ce_s   = r_ce_sync[SYNC_STAGES-1];
   assign w_we_s   = r_we_sync[SYNC_STAGES-1];
   assign w_rd_s   = r_rd_sync[SYNC_STAGES-1];
   assign w_wr_act = ~w_ce_s & ~w_we_s;
   assign w_rd_act = ~w_ce_s & ~w_rd_s;

   // Strobe synchronisers; they reset to the idle (high) bus level. r_settle marks
   // when the synchronisers have fully refilled from the pins after reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ce_sync <= '1;
         r_we_sync <= '1;
         r_rd_sync <= '1;
         r_settle  <= '0;
      end else begin
         r_ce_sync <= {r_ce_sync[SYNC_STAGES-2:0], i_dsp_ce};
         r_we_sync <= {r_we_sync[SYNC_STAGES-2:0], i_dsp_we};
         r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], i_dsp_rd};
         r_settle  <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state decode plus single-cycle event strobes for the datapath.
   always_comb begin
      w_state_next = r_state;
      w_conflict   = 1'b0;
      w_rd_capture = 1'b0;
      w_rd_done    = 1'b0;
      w_wr_commit  = 1'b0;
      w_wf_wr_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_armed) begin
               if (w_rd_act && w_wr_act) w_conflict   = 1'b1;
               else if (w_rd_act)        w_state_next = S_RD_ISSUE;
               else if (w_wr_act)        w_state_next = S_WR_HOLD;
            end
         end
         S_RD_ISSUE: begin
            if (w_ce_s) w_state_next = S_IDLE;
            else        w_state_next = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (w_ce_s) begin
               w_state_next = S_IDLE;
            end else if (r_lat_cnt == 3'(RD_LAT - 1)) begin
               w_rd_capture = 1'b1;
               w_state_next = S_RD_HOLD;
            end
         end
         S_RD_HOLD: begin
            if (!w_rd_act) begin
               w_rd_done    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_WR_HOLD: begin
            if (!w_wr_act) w_state_next = S_WR_COMMIT;
         end
         S_WR_COMMIT: begin
            if (r_wf) w_wf_wr_err = 1'b1;
            else      w_wr_commit = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_start = (r_state == S_IDLE) && (w_state_next != S_IDLE);

   // Transaction datapath: address/data capture, read latency count, read data,
   // sticky error, saturating counters and the post-reset arming flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_armed   <= 1'b0;
         r_addr    <= '0;
         r_din     <= '0;
         r_wf      <= 1'b0;
         r_lat_cnt <= '0;
         r_xd      <= '0;
         r_err     <= 1'b0;
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
      end else begin
         // A strobe still held low across reset release is not a new access.
         if (r_settle[SYNC_STAGES-1] && !w_wr_act && !w_rd_act) r_armed <= 1'b1;
         if (w_start) r_wf <= i_wf_en;
         if (w_start || (r_state == S_WR_HOLD && w_wr_act)) begin
            r_addr <= i_dsp_xa;
            r_din  <= i_dsp_xd;
         end
         if (r_state == S_RD_ISSUE)     r_lat_cnt <= '0;
         else if (r_state == S_RD_WAIT) r_lat_cnt <= r_lat_cnt + 3'd1;
         if (w_rd_capture) r_xd <= r_wf ? i_wf_ram_dout : i_r_ram_dout;
         if (w_conflict || w_wf_wr_err) r_err <= 1'b1;
         if (w_wr_commit && (r_wr_cnt != {CNT_W{1'b1}})) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
         if (w_rd_done && (r_rd_cnt != {CNT_W{1'b1}}))   r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
   end

   // RAM ports are zero except in the single cycle that pulses them.
   assign o_r_ram_ce    = (r_state == S_RD_ISSUE) && !r_wf;
   assign o_r_ram_addr  = o_r_ram_ce ? r_addr : '0;
   assign o_wf_ram_ce   = (r_state == S_RD_ISSUE) && r_wf;
   assign o_wf_ram_addr = o_wf_ram_ce ? r_addr : '0;
   assign o_w_ram_ce    = w_wr_commit;
   assign o_w_ram_we    = w_wr_commit;
   assign o_w_ram_addr  = w_wr_commit ? r_addr : '0;
   assign o_w_ram_din   = w_wr_commit ? r_din : '0;

   // Output enable drops in the same cycle the synchronised RD or CE releases.
   assign o_dsp_xd_oe = (r_state == S_RD_HOLD) && w_rd_act;
   assign o_dsp_xd    = r_xd;
   assign o_wr_cnt    = r_wr_cnt;
   assign o_rd_cnt    = r_rd_cnt;
   assign o_err       = r_err;
   assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_xintf_dpbram_bridge.sv
// Directed bench for xintf_dpbram_bridge with RAM models and a write/read scoreboard.
module tb_xintf_dpbram_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wf_en = 1'b0;
   logic        ce = 1'b1, we = 1'b1, rd = 1'b1;
   logic [8:0]  xa = '0;
   logic [15:0] xd = '0;
   logic [15:0] dsp_xd;
   logic        dsp_xd_oe;
   logic [8:0]  w_addr, r_addr, wf_addr;
   logic        w_ce, w_we, r_ce, wf_ce;
   logic [15:0] w_din;
   logic [15:0] r_dout = '0, wf_dout = '0;
   logic [3:0]  wr_cnt, rd_cnt;
   logic        err, busy;

   typedef struct packed {
      logic [8:0]  a;
      logic [15:0] d;
   } wr_t;

   wr_t         wq[$];
   logic [15:0] rq[$];
   logic [15:0] cmem [0:511];
   logic [15:0] wmem [0:511];

   int total = 0;
   int bad = 0;
   int w_pulses = 0;
   int r_ce_cnt = 0;
   int wf_ce_cnt = 0;
   logic oe_prev = 1'b0;

   xintf_dpbram_bridge #(
      .AW(9), .DW(16), .SYNC_STAGES(2), .RD_LAT(1), .CNT_W(4)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_wf_en(wf_en),
      .i_dsp_ce(ce), .i_dsp_we(we), .i_dsp_rd(rd),
      .i_dsp_xa(xa), .i_dsp_xd(xd),
      .o_dsp_xd(dsp_xd), .o_dsp_xd_oe(dsp_xd_oe),
      .o_w_ram_addr(w_addr), .o_w_ram_ce(w_ce), .o_w_ram_we(w_we), .o_w_ram_din(w_din),
      .o_r_ram_addr(r_addr), .o_r_ram_ce(r_ce), .i_r_ram_dout(r_dout),
      .o_wf_ram_addr(wf_addr), .o_wf_ram_ce(wf_ce), .i_wf_ram_dout(wf_dout),
      .o_wr_cnt(wr_cnt), .o_rd_cnt(rd_cnt), .o_err(err), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Control RAM: registered write and one-clock registered read.
   always @(posedge clk) begin
      if (w_ce && w_we) cmem[w_addr] <= w_din;
      if (r_ce) r_dout <= cmem[r_addr];
   end

   // Waveform RAM: read only, one-clock registered read.
   always @(posedge clk) begin
      if (wf_ce) wf_dout <= wmem[wf_addr];
   end

   // Scoreboard monitor sampling on the falling edge.
   always @(negedge clk) begin
      wr_t e;
      if (w_ce || w_we) begin
         w_pulses++;
         $display("wr pulse addr=%03h din=%04h", w_addr, w_din);
         if (wq.size() == 0) begin
            chk("wr_unexpected", 1, 0);
         end else begin
            e = wq.pop_front();
            chk("wr_addr", w_addr, e.a);
            chk("wr_din", w_din, e.d);
            chk("wr_ce_we", {w_ce, w_we}, 2'b11);
         end
      end
      if (r_ce)  r_ce_cnt++;
      if (wf_ce) wf_ce_cnt++;
      if (dsp_xd_oe && !oe_prev) begin
         $display("rd data xd=%04h", dsp_xd);
         if (rq.size() == 0) chk("rd_unexpected", 1, 0);
         else                chk("rd_data", dsp_xd, rq.pop_front());
      end
      oe_prev = dsp_xd_oe;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [8:0] a, input logic [15:0] d, input int lo, input int hi);
      xa = a; xd = d; ce = 1'b0; we = 1'b0;
      tick(lo);
      ce = 1'b1; we = 1'b1;
      tick(hi);
   endtask

   // Read access: returns clocks from RD fall until OE is seen (30 = never).
   task automatic bus_read(input logic [8:0] a, output int lat);
      xa = a; ce = 1'b0; rd = 1'b0; lat = 0;
      while (dsp_xd_oe !== 1'b1 && lat < 30) begin
         tick(1);
         lat++;
      end
      tick(2);
      ce = 1'b1; rd = 1'b1;
      tick(5);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(3);
   endtask

   initial begin
      int lat;
      int snap_p, snap_r, snap_wf;
      bit oe_seen;

      cmem[9'h100] = 16'h1234;
      cmem[9'h010] = 16'h1111;
      wmem[9'h010] = 16'hCAFE;

      // Reset state
      tick(3);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_oe", dsp_xd_oe, 0);
      chk("rst_wr_cnt", wr_cnt, 0);
      chk("rst_rd_cnt", rd_cnt, 0);
      chk("rst_w_ce", w_ce, 0);
      rst = 1'b0;
      tick(4);

      // T1: single write
      wq.push_back('{a: 9'h05A, d: 16'hBEEF});
      bus_write(9'h05A, 16'hBEEF, 8, 6);
      chk("t1_wr_cnt", wr_cnt, 1);
      chk("t1_pulses", w_pulses, 1);
      chk("t1_busy", busy, 0);

      // T2: read with latency measurement
      rq.push_back(16'h1234);
      xa = 9'h100; ce = 1'b0; rd = 1'b0; lat = 0;
      while (dsp_xd_oe !== 1'b1 && lat < 30) begin
         tick(1);
         lat++;
      end
      chk("t2_oe_latency", lat, 5);
      chk("t2_xd", dsp_xd, 16'h1234);
      tick(2);
      chk("t2_oe_held", dsp_xd_oe, 1);
      ce = 1'b1; rd = 1'b1;
      tick(4);
      chk("t2_oe_off", dsp_xd_oe, 0);
      chk("t2_rd_cnt", rd_cnt, 1);
      chk("t2_err", err, 0);

      // Read back the address written in T1
      rq.push_back(16'hBEEF);
      bus_read(9'h05A, lat);
      chk("t2b_rd_cnt", rd_cnt, 2);

      // T3: waveform-mode read, then rejected write
      wf_en = 1'b1;
      snap_r = r_ce_cnt; snap_wf = wf_ce_cnt;
      rq.push_back(16'hCAFE);
      bus_read(9'h010, lat);
      chk("t3_oe_latency", lat, 5);
      chk("t3_r_ce_none", r_ce_cnt, snap_r);
      chk("t3_wf_ce_once", wf_ce_cnt, snap_wf + 1);
      chk("t3_rd_cnt", rd_cnt, 3);
      snap_p = w_pulses;
      bus_write(9'h020, 16'hAAAA, 4, 6);
      chk("t3_wf_wr_err", err, 1);
      chk("t3_wf_wr_nopulse", w_pulses, snap_p);
      chk("t3_wf_wr_cnt", wr_cnt, 1);
      wf_en = 1'b0;

      do_reset();
      chk("rst2_err", err, 0);
      chk("rst2_wr_cnt", wr_cnt, 0);

      // T4: WE and RD both low
      snap_p = w_pulses; oe_seen = 0;
      xa = 9'h033; ce = 1'b0; we = 1'b0; rd = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (dsp_xd_oe) oe_seen = 1;
      end
      ce = 1'b1; we = 1'b1; rd = 1'b1;
      tick(6);
      chk("t4_err", err, 1);
      chk("t4_oe_never", oe_seen, 0);
      chk("t4_nopulse", w_pulses, snap_p);
      tick(4);
      chk("t4_err_sticky", err, 1);

      do_reset();

      // T5a: CE released while the read is in its RAM wait cycle
      oe_seen = 0;
      xa = 9'h100; ce = 1'b0; rd = 1'b0;
      tick(2);
      ce = 1'b1; rd = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (dsp_xd_oe) oe_seen = 1;
      end
      chk("t5_abort_oe", oe_seen, 0);
      chk("t5_abort_rd_cnt", rd_cnt, 0);
      chk("t5_abort_busy", busy, 0);

      // T5b: reset pulse during write hold, strobe held low across release
      snap_p = w_pulses;
      xa = 9'h077; xd = 16'h7777; ce = 1'b0; we = 1'b0;
      tick(4);
      chk("t5_pre_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("t5_async_busy", busy, 0);
      chk("t5_async_w_ce", w_ce, 0);
      tick(2);
      rst = 1'b0;
      tick(5);
      ce = 1'b1; we = 1'b1;
      tick(8);
      chk("t5_rst_nopulse", w_pulses, snap_p);
      chk("t5_rst_wr_cnt", wr_cnt, 0);
      chk("t5_rst_busy", busy, 0);

      // T6: 20 back-to-back writes, counter saturates at 0xF
      snap_p = w_pulses;
      for (int i = 0; i < 20; i++) begin
         logic [8:0]  a;
         logic [15:0] d;
         a = 9'(i * 3 + 1);
         d = 16'(i * 16'h0101) ^ 16'h5A00;
         wq.push_back('{a: a, d: d});
         bus_write(a, d, 2, 2);
      end
      tick(6);
      chk("t6_pulses", w_pulses, snap_p + 20);
      chk("t6_wr_cnt_sat", wr_cnt, 4'hF);
      chk("t6_err", err, 0);

      chk("end_wq_empty", wq.size(), 0);
      chk("end_rq_empty", rq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
